// File: rtl/argon_alu_sequencer.sv
// Sequences the ArgonALU bus for one requester: latch operands/opcode/flags,
// compute, read back Y and flags, then return them on a valid/ready response port.
package argon_alu_sequencer_pkg;
  typedef enum logic [3:0] {
    COM_NOP     = 4'd0,
    COM_LATCHA  = 4'd1,
    COM_LATCHB  = 4'd2,
    COM_LATCHOP = 4'd3,
    COM_LATCHF  = 4'd4,
    COM_COMPUTE = 4'd5,
    COM_OUTPUTY = 4'd6,
    COM_OUTPUTF = 4'd7
  } command_t;
endpackage

module argon_alu_sequencer
  import argon_alu_sequencer_pkg::*;
#(
  parameter int WORDSIZE = 16,
  parameter int TIMEOUT  = 8
) (
  input  logic                i_Clk,
  input  logic                i_Reset_n,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [3:0]          i_req_op,
  input  logic [WORDSIZE-1:0] i_req_a,
  input  logic [WORDSIZE-1:0] i_req_b,
  input  logic [7:0]          i_req_flags,
  input  logic                i_req_load_flags,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [WORDSIZE-1:0] o_rsp_y,
  output logic [7:0]          o_rsp_flags,
  output logic                o_rsp_timeout,
  output logic                o_busy,
  output command_t            o_alu_command,
  output logic                o_alu_valid,
  output logic [WORDSIZE-1:0] o_alu_data,
  input  logic [WORDSIZE-1:0] i_alu_data,
  input  logic                i_alu_valid
);

  typedef enum logic [3:0] {
    S_IDLE, S_LDA, S_LDB, S_LDOP, S_LDF, S_COMPUTE, S_RDY, S_RDF, S_RESP
  } state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t              state_q, state_d;
  logic [WORDSIZE-1:0] a_q, b_q, y_q;
  logic [3:0]          op_q;
  logic [7:0]          flags_q, rflags_q, cnt_q;
  logic                lf_q, to_q;
  logic                tmo_hit;

  assign tmo_hit = (cnt_q == TMO) && !i_alu_valid;

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (i_req_valid) state_d = S_LDA;
      S_LDA:     state_d = S_LDB;
      S_LDB:     state_d = S_LDOP;
      S_LDOP:    state_d = lf_q ? S_LDF : S_COMPUTE;
      S_LDF:     state_d = S_COMPUTE;
      S_COMPUTE: state_d = S_RDY;
      S_RDY: begin
        if (i_alu_valid)  state_d = S_RDF;
        else if (tmo_hit) state_d = S_RESP;
      end
      S_RDF:     if (i_alu_valid || tmo_hit) state_d = S_RESP;
      S_RESP:    if (i_rsp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Wait counter restarts on every state change, so RDY and RDF each get a full budget.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (state_q == S_RDY || state_q == S_RDF) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      flags_q  <= '0;
      lf_q     <= 1'b0;
      y_q      <= '0;
      rflags_q <= '0;
      to_q     <= 1'b0;
    end else begin
      if (state_q == S_IDLE && i_req_valid) begin
        a_q      <= i_req_a;
        b_q      <= i_req_b;
        op_q     <= i_req_op;
        flags_q  <= i_req_flags;
        lf_q     <= i_req_load_flags;
        y_q      <= '0;
        rflags_q <= '0;
        to_q     <= 1'b0;
      end
      if (state_q == S_RDY && i_alu_valid) y_q <= i_alu_data;
      if (state_q == S_RDF && i_alu_valid) rflags_q <= i_alu_data[7:0];
      if ((state_q == S_RDY || state_q == S_RDF) && tmo_hit) to_q <= 1'b1;
    end
  end

  always_comb begin
    o_alu_command = COM_NOP;
    o_alu_valid   = 1'b0;
    o_alu_data    = '0;
    case (state_q)
      S_LDA: begin
        o_alu_command = COM_LATCHA;
        o_alu_valid   = 1'b1;
        o_alu_data    = a_q;
      end
      S_LDB: begin
        o_alu_command = COM_LATCHB;
        o_alu_valid   = 1'b1;
        o_alu_data    = b_q;
      end
      S_LDOP: begin
        o_alu_command = COM_LATCHOP;
        o_alu_valid   = 1'b1;
        o_alu_data    = {{(WORDSIZE-4){1'b0}}, op_q};
      end
      S_LDF: begin
        o_alu_command = COM_LATCHF;
        o_alu_valid   = 1'b1;
        o_alu_data    = {{(WORDSIZE-8){1'b0}}, flags_q};
      end
      S_COMPUTE: o_alu_command = COM_COMPUTE;
      S_RDY:     o_alu_command = COM_OUTPUTY;
      S_RDF:     o_alu_command = COM_OUTPUTF;
      default:   o_alu_command = COM_NOP;
    endcase
  end

  assign o_req_ready   = (state_q == S_IDLE);
  assign o_busy        = (state_q != S_IDLE);
  assign o_rsp_valid   = (state_q == S_RESP);
  assign o_rsp_y       = y_q;
  assign o_rsp_flags   = rflags_q;
  assign o_rsp_timeout = to_q;

endmodule

// File: tb/tb_argon_alu_sequencer.sv
// Scoreboard bench for argon_alu_sequencer driving a small behavioural ArgonALU;
// directed requests push hand-computed responses, a negedge monitor pops and compares.
module tb_argon_alu_sequencer;
  import argon_alu_sequencer_pkg::*;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_ADC = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, o_req_ready;
  logic [3:0]  i_req_op;
  logic [15:0] i_req_a, i_req_b;
  logic [7:0]  i_req_flags;
  logic        i_req_load_flags;
  logic        o_rsp_valid, i_rsp_ready;
  logic [15:0] o_rsp_y;
  logic [7:0]  o_rsp_flags;
  logic        o_rsp_timeout, o_busy;
  command_t    o_alu_command;
  logic        o_alu_valid;
  logic [15:0] o_alu_data, i_alu_data;
  logic        i_alu_valid;

  always #5 clk = ~clk;

  argon_alu_sequencer #(.WORDSIZE(16), .TIMEOUT(4)) dut (
    .i_Clk(clk), .i_Reset_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_op(i_req_op), .i_req_a(i_req_a), .i_req_b(i_req_b),
    .i_req_flags(i_req_flags), .i_req_load_flags(i_req_load_flags),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_y(o_rsp_y), .o_rsp_flags(o_rsp_flags), .o_rsp_timeout(o_rsp_timeout),
    .o_busy(o_busy), .o_alu_command(o_alu_command), .o_alu_valid(o_alu_valid),
    .o_alu_data(o_alu_data), .i_alu_data(i_alu_data), .i_alu_valid(i_alu_valid)
  );

  // Behavioural ALU: flags are {N, Z, C} in bits 2..0; carry means borrow for SUB.
  logic [15:0] alu_a, alu_b, alu_y;
  logic [3:0]  alu_op;
  logic [7:0]  alu_f;
  logic [16:0] alu_r;
  logic        alu_mute;

  always @(posedge clk) begin
    if (o_alu_valid) begin
      case (o_alu_command)
        COM_LATCHA:  alu_a  <= o_alu_data;
        COM_LATCHB:  alu_b  <= o_alu_data;
        COM_LATCHOP: alu_op <= o_alu_data[3:0];
        COM_LATCHF:  alu_f  <= o_alu_data[7:0];
        default: ;
      endcase
    end
    if (o_alu_command == COM_COMPUTE) begin
      case (alu_op)
        ALU_ADD: alu_r = {1'b0, alu_a} + {1'b0, alu_b};
        ALU_ADC: alu_r = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_f[0]};
        ALU_SUB: alu_r = {1'b0, alu_a} - {1'b0, alu_b};
        default: alu_r = '0;
      endcase
      alu_y <= alu_r[15:0];
      alu_f <= {5'd0, alu_r[15], (alu_r[15:0] == 16'd0), alu_r[16]};
    end
  end

  assign i_alu_valid = !alu_mute &&
                       (o_alu_command == COM_OUTPUTY || o_alu_command == COM_OUTPUTF);
  assign i_alu_data  = (o_alu_command == COM_OUTPUTF) ? {8'h00, alu_f} : alu_y;

  typedef struct {
    logic [15:0] y;
    logic [7:0]  f;
    logic        to;
    int          lat;
    logic [31:0] cmds;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Monitor
  int          acc_edge = 0, hs_edge = 0, rise_cyc = 0;
  logic [31:0] cmd_log = '0;
  command_t    last_cmd = COM_NOP;
  logic        in_rsp = 1'b0, chk_gap = 1'b0;
  logic [15:0] hy;
  logic [7:0]  hf;
  logic        hto;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_rsp   = 1'b0;
      cmd_log  = '0;
      last_cmd = COM_NOP;
    end else begin
      if (o_alu_command != COM_NOP && o_alu_command != last_cmd)
        cmd_log = {cmd_log[27:0], 4'(o_alu_command)};
      last_cmd = o_alu_command;
      if (o_rsp_valid) begin
        if (!in_rsp) begin
          in_rsp = 1'b1; rise_cyc = cyc;
          hy = o_rsp_y; hf = o_rsp_flags; hto = o_rsp_timeout;
        end else begin
          check("hold_y", 32'(o_rsp_y), 32'(hy));
          check("hold_flags", 32'(o_rsp_flags), 32'(hf));
          check("hold_timeout", 32'(o_rsp_timeout), 32'(hto));
        end
        check("req_ready_in_resp", 32'(o_req_ready), 32'd0);
        if (i_rsp_ready) begin
          if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rsp: got y=%h with no expectation queued", o_rsp_y);
          end else begin
            e = sbq.pop_front();
            check("rsp_y", 32'(o_rsp_y), 32'(e.y));
            check("rsp_flags", 32'(o_rsp_flags), 32'(e.f));
            check("rsp_timeout", 32'(o_rsp_timeout), 32'(e.to));
            check("rsp_latency", 32'(rise_cyc - acc_edge + 1), 32'(e.lat));
            check("alu_cmds", cmd_log, e.cmds);
          end
          in_rsp  = 1'b0;
          hs_edge = cyc + 1;
        end
      end
      if (o_req_ready && i_req_valid) begin
        acc_edge = cyc + 1;
        cmd_log  = '0;
        if (chk_gap) begin
          check("accept_after_handshake", 32'(acc_edge - hs_edge), 32'd1);
          chk_gap = 1'b0;
        end
      end
    end
  end

  task automatic push_exp(input logic [15:0] y, input logic [7:0] f, input logic to,
                          input int lat, input logic [31:0] cmds);
    exp_t x;
    x.y = y; x.f = f; x.to = to; x.lat = lat; x.cmds = cmds;
    sbq.push_back(x);
  endtask

  task automatic drive_req(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                           input logic [7:0] fl, input logic lf);
    i_req_a = a; i_req_b = b; i_req_op = op; i_req_flags = fl; i_req_load_flags = lf;
    i_req_valid = 1'b1;
  endtask

  task automatic wait_accept();
    bit ok = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (o_req_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    if (!ok) check("accept_wait", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                      input logic [7:0] fl, input logic lf, input logic [15:0] ey,
                      input logic [7:0] ef, input logic eto, input int lat,
                      input logic [31:0] cmds);
    push_exp(ey, ef, eto, lat, cmds);
    drive_req(a, b, op, fl, lf);
    wait_accept();
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !o_rsp_valid) break;
    end
    check("drain", 32'(sbq.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(o_req_ready), 32'd1);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
    check({tag, "_rsp_y"}, 32'(o_rsp_y), 32'd0);
    check({tag, "_rsp_flags"}, 32'(o_rsp_flags), 32'd0);
    check({tag, "_rsp_timeout"}, 32'(o_rsp_timeout), 32'd0);
    check({tag, "_alu_cmd"}, 32'(o_alu_command), 32'(COM_NOP));
    check({tag, "_alu_valid"}, 32'(o_alu_valid), 32'd0);
    check({tag, "_alu_data"}, 32'(o_alu_data), 32'd0);
  endtask

  localparam logic [31:0] SEQ_PLAIN = 32'h0012_3567;
  localparam logic [31:0] SEQ_PRELD = 32'h0123_4567;
  localparam logic [31:0] SEQ_TMO_Y = 32'h0001_2356;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; i_req_valid = 1'b0; i_rsp_ready = 1'b1;
    i_req_a = '0; i_req_b = '0; i_req_op = '0; i_req_flags = '0; i_req_load_flags = 1'b0;
    alu_mute = 1'b0; alu_a = '0; alu_b = '0; alu_y = '0; alu_op = '0; alu_f = '0; alu_r = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    send(16'h0001, 16'h0002, ALU_ADD, 8'h00, 1'b0, 16'h0003, 8'h00, 1'b0, 7, SEQ_PLAIN);
    wait_drain();
    send(16'hFFFF, 16'h0001, ALU_ADD, 8'h00, 1'b0, 16'h0000, 8'h03, 1'b0, 7, SEQ_PLAIN);
    wait_drain();
    send(16'h0001, 16'h0001, ALU_ADC, 8'h00, 1'b0, 16'h0003, 8'h00, 1'b0, 7, SEQ_PLAIN);
    wait_drain();
    send(16'h0001, 16'h0001, ALU_ADC, 8'h01, 1'b1, 16'h0003, 8'h00, 1'b0, 8, SEQ_PRELD);
    wait_drain();

    // Backpressure with a second request waiting behind the stalled response.
    i_rsp_ready = 1'b0;
    send(16'h1234, 16'h1111, ALU_ADD, 8'h00, 1'b0, 16'h2345, 8'h00, 1'b0, 7, SEQ_PLAIN);
    push_exp(16'hFFFE, 8'h05, 1'b0, 7, SEQ_PLAIN);
    drive_req(16'h0005, 16'h0007, ALU_SUB, 8'h00, 1'b0);
    chk_gap = 1'b1;
    for (int n = 0; n < 50 && !o_rsp_valid; n++) @(posedge clk);
    check("bp_rsp_seen", 32'(o_rsp_valid), 32'd1);
    repeat (5) @(posedge clk);
    #1 i_rsp_ready = 1'b1;
    wait_accept();
    wait_drain();

    alu_mute = 1'b1;
    send(16'h0005, 16'h0006, ALU_ADD, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b1, 10, SEQ_TMO_Y);
    wait_drain();
    alu_mute = 1'b0;

    // Abort in LDB: nothing is queued, so any response would be flagged by the monitor.
    drive_req(16'h00AA, 16'h00BB, ALU_ADD, 8'h00, 1'b0);
    wait_accept();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (o_alu_command == COM_LATCHB) break;
    end
    check("saw_ldb", 32'(o_alu_command), 32'(COM_LATCHB));
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("post_abort_idle", 32'(o_busy), 32'd0);

    send(16'h0010, 16'h0020, ALU_ADD, 8'h00, 1'b0, 16'h0030, 8'h00, 1'b0, 7, SEQ_PLAIN);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
